// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream requesters, the arbiter and uart_tx.
// master = arbiter side, slave = requester/uart_tx side.
interface uart_tx_arbiter_if #(
   parameter int unsigned G_NUM_REQ   = 4,
   parameter int unsigned G_DATAWIDTH = 8
);
   localparam int unsigned IdW = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1;

   logic [G_NUM_REQ*G_DATAWIDTH-1:0] req_data;
   logic [G_NUM_REQ-1:0]             req_valid;
   logic [G_NUM_REQ-1:0]             req_last;
   logic [G_NUM_REQ-1:0]             req_ready;
   logic [G_DATAWIDTH-1:0]           uart_txdata;
   logic                             uart_txvalid;
   logic                             uart_txready;
   logic [G_NUM_REQ-1:0]             grant;
   logic [IdW-1:0]                   grant_id;
   logic                             busy;

   modport master (
      input  req_data, req_valid, req_last, uart_txready,
      output req_ready, uart_txdata, uart_txvalid, grant, grant_id, busy
   );

   modport slave (
      output req_data, req_valid, req_last, uart_txready,
      input  req_ready, uart_txdata, uart_txvalid, grant, grant_id, busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte port between G_NUM_REQ requesters.
// A grant is held for a whole message, cut short by the burst cap when enabled.
module uart_tx_arbiter #(
   parameter int unsigned G_NUM_REQ   = 4,
   parameter int unsigned G_DATAWIDTH = 8,
   parameter int unsigned G_MAX_BURST = 16
) (
   input logic                i_clk,
   input logic                i_rst_n,
   uart_tx_arbiter_if.master  io_bus
);
   localparam int unsigned IdW = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1;

   typedef enum logic {StIdle, StXfer} state_t;

   state_t                r_state, w_state_d;
   logic [IdW-1:0]        r_ptr, w_ptr_d;
   logic [G_NUM_REQ-1:0]  r_grant, w_grant_d;
   logic [IdW-1:0]        r_grant_id, w_grant_id_d;
   logic                  r_busy, w_busy_d;
   logic [7:0]            r_count, w_count_d;

   logic                  w_sel_found;
   logic [IdW-1:0]        w_sel_id;
   logic                  w_owner_last;
   logic                  w_beat;
   logic [8:0]            w_cnt_inc;
   logic                  w_cap_hit;
   logic                  w_release;

   // First valid requester searching ptr+1, ptr+2, ... mod N.
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_id    = '0;
      for (int unsigned k = 1; k <= G_NUM_REQ; k++) begin
         logic [IdW-1:0] v_idx;
         v_idx = IdW'((32'(r_ptr) + k) % G_NUM_REQ);
         if (!w_sel_found && io_bus.req_valid[v_idx]) begin
            w_sel_found = 1'b1;
            w_sel_id    = v_idx;
         end
      end
   end

   // Owner mux; r_grant is all zero when idle so every output falls to 0.
   always_comb begin
      io_bus.uart_txdata  = '0;
      io_bus.uart_txvalid = 1'b0;
      io_bus.req_ready    = '0;
      w_owner_last        = 1'b0;
      for (int unsigned i = 0; i < G_NUM_REQ; i++) begin
         if (r_grant[i]) begin
            io_bus.uart_txdata  = io_bus.req_data[i*G_DATAWIDTH +: G_DATAWIDTH];
            io_bus.uart_txvalid = io_bus.req_valid[i];
            io_bus.req_ready[i] = io_bus.uart_txready;
            w_owner_last        = io_bus.req_last[i];
         end
      end
   end

   assign w_beat    = io_bus.uart_txvalid & io_bus.uart_txready;
   assign w_cnt_inc = {1'b0, r_count} + 9'd1;
   assign w_cap_hit = (G_MAX_BURST != 0) && (w_cnt_inc == 9'(G_MAX_BURST));
   assign w_release = w_beat & (w_owner_last | w_cap_hit);

   always_comb begin
      w_state_d    = r_state;
      w_ptr_d      = r_ptr;
      w_grant_d    = r_grant;
      w_grant_id_d = r_grant_id;
      w_busy_d     = r_busy;
      w_count_d    = r_count;
      unique case (r_state)
         StIdle: begin
            if (w_sel_found) begin
               w_state_d    = StXfer;
               w_grant_d    = G_NUM_REQ'(1) << w_sel_id;
               w_grant_id_d = w_sel_id;
               w_busy_d     = 1'b1;
            end
         end
         StXfer: begin
            if (w_beat) begin
               w_count_d = w_cnt_inc[7:0];
            end
            if (w_release) begin
               w_state_d    = StIdle;
               w_ptr_d      = r_grant_id;
               w_count_d    = '0;
               w_grant_d    = '0;
               w_grant_id_d = '0;
               w_busy_d     = 1'b0;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_ptr      <= IdW'(G_NUM_REQ - 1);
         r_grant    <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_d;
         r_ptr      <= w_ptr_d;
         r_grant    <= w_grant_d;
         r_grant_id <= w_grant_id_d;
         r_busy     <= w_busy_d;
         r_count    <= w_count_d;
      end
   end

   assign io_bus.grant    = r_grant;
   assign io_bus.grant_id = r_grant_id;
   assign io_bus.busy     = r_busy;
endmodule
